// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: AES-128 key expansion sequencer; drives an external F stage once per round
// and keeps every generated round key in a random-access store.
module aes_key_sched_ctrl #(
    parameter int NUM_ROUNDS     = 10,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         error_o,
    output logic         kexp_en_o,
    output logic [31:0]  kexp_word_o,
    output logic [7:0]   kexp_rcon_o,
    output logic [127:0] kexp_key_o,
    input  logic         kexp_ready_i,
    input  logic [127:0] kexp_key_i,
    input  logic [3:0]   rd_round_i,
    output logic [127:0] rd_key_o,
    output logic         rd_valid_o
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, STORE, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic [3:0]    round_q, round_d, valid_q, valid_d;
    logic [7:0]    rcon_q, rcon_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [127:0]  store_q [NUM_ROUNDS+1];
    logic          wr_en;
    logic [3:0]    wr_idx, prev_idx;
    logic [127:0]  wr_data;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        valid_d = valid_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_idx  = round_q;
        wr_data = kexp_key_i;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = REQ;
                wr_en   = 1'b1;
                wr_idx  = 4'd0;
                wr_data = key_i;
                valid_d = 4'd1;
                round_d = 4'd1;
                rcon_d  = 8'h01;
                err_d   = 1'b0;
            end
            REQ: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (kexp_ready_i) begin
                wr_en   = 1'b1;
                valid_d = round_q + 4'd1;
                state_d = STORE;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ERR;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            STORE: if (round_q == 4'(NUM_ROUNDS)) begin
                state_d = DONE;
            end else begin
                round_d = round_q + 4'd1;
                rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                state_d = REQ;
            end
            DONE: state_d = IDLE;
            ERR: begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            round_q <= '0;
            valid_q <= '0;
            rcon_q  <= 8'h01;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) store_q[i] <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            valid_q <= valid_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (wr_en) store_q[wr_idx] <= wr_data;
        end
    end

    // F-stage outputs are forced to zero whenever the enable is low so idle/reset reads clean
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign error_o     = err_q;
    assign kexp_en_o   = (state_q == REQ) || (state_q == WAIT);
    assign prev_idx    = kexp_en_o ? round_q - 4'd1 : 4'd0;
    assign kexp_key_o  = kexp_en_o ? store_q[prev_idx] : '0;
    assign kexp_word_o = kexp_key_o[31:0];
    assign kexp_rcon_o = kexp_en_o ? rcon_q : '0;
    assign rd_key_o    = (rd_round_i <= 4'(NUM_ROUNDS)) ? store_q[rd_round_i] : '0;
    assign rd_valid_o  = rd_round_i < valid_q;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: randomized scoreboard bench with a behavioural AES F-stage and key-expansion model.
module tb_aes_key_sched_ctrl;
    localparam int NR = 10;
    localparam int TO = 64;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic clk = 0, rst = 1, start = 0, ready = 0;
    logic [127:0] key = '0, kkey_i = '0;
    logic [3:0] rd_round = '0;
    logic busy, done, error, en, rd_valid;
    logic [31:0] word;
    logic [7:0] rcon;
    logic [127:0] kkey_o, rd_key;

    aes_key_sched_ctrl #(.NUM_ROUNDS(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .key_i(key),
        .busy_o(busy), .done_o(done), .error_o(error),
        .kexp_en_o(en), .kexp_word_o(word), .kexp_rcon_o(rcon), .kexp_key_o(kkey_o),
        .kexp_ready_i(ready), .kexp_key_i(kkey_i),
        .rd_round_i(rd_round), .rd_key_o(rd_key), .rd_valid_o(rd_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0, n_chk = 0;
    logic [7:0] sbox [256];
    logic [7:0] rcon_tab [NR] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] exp_store [NR+1];
    logic [127:0] pend [NR+1];
    logic [135:0] req_q [$];
    int done_q [$];
    int req_seen = 0;
    int f_lat = 2;
    bit f_never = 0, f_spur = 0, en_prev = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        n_chk++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 0, x = a, y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // One AES-128 expansion round: RotWord, SubWord, rcon, then the running XOR chain
    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox[k[23:16]], sbox[k[15:8]], sbox[k[7:0]], sbox[k[31:24]]} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // F-stage model: ready after f_lat low WAIT cycles; optional spurious ready outside WAIT
    initial begin : fstage
        int fcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            fcnt = en ? fcnt + 1 : 0;
            if (en && fcnt >= f_lat + 2 && !f_never) begin
                ready = 1;
                kkey_i = next_key(kkey_o, rcon);
            end else if (f_spur && fcnt <= 1) begin
                ready = 1;
                kkey_i = rnd128();
            end else begin
                ready = 0;
                kkey_i = rnd128();
            end
        end
    end

    initial begin : monitor
        logic [135:0] cur;
        bit have = 0;
        forever begin
            @(negedge clk);
            if (en && !en_prev) begin
                req_seen++;
                if (req_q.size() == 0) begin
                    fail("unexpected_request: got a request, expected none");
                    have = 0;
                end else begin
                    cur = req_q.pop_front();
                    have = 1;
                    chk("req_rcon_key", {rcon, kkey_o}, cur);
                    chk("req_word", 128'(word), 128'(cur[31:0]));
                end
            end else if (en && have) begin
                chk("held_rcon_key", {rcon, kkey_o}, cur);
            end
            en_prev = en;
            if (done) begin
                if (done_q.size() == 0) fail("unexpected_done: got done pulse, expected none");
                else chk("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
            end
        end
    end

    task automatic start_run(input logic [127:0] k, output int sc);
        pend[0] = k;
        for (int i = 1; i <= NR; i++) pend[i] = next_key(pend[i-1], rcon_tab[i-1]);
        for (int i = 0; i < NR; i++) req_q.push_back({rcon_tab[i], pend[i]});
        exp_store[0] = k;
        key = k;
        start = 1;
        sc = cyc;
        done_q.push_back(sc + NR * (3 + f_lat) + 1);
        @(posedge clk);
        #1;
        start = 0;
        chk("accept_busy", 128'(busy), 128'(1));
        chk("accept_error_cleared", 128'(error), 128'(0));
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = done;
        end
        if (!ok) fail("done_timeout: got no done, expected done");
        else for (int i = 1; i <= NR; i++) exp_store[i] = pend[i];
        @(posedge clk);
        #1;
        chk("idle_busy", 128'(busy), 128'(0));
    endtask

    task automatic check_store(input int nv);
        for (int i = 0; i < 16; i++) begin
            rd_round = 4'(i);
            #0.5;
            chk($sformatf("rd_key[%0d]", i), rd_key, i <= NR ? exp_store[i] : 128'h0);
            chk($sformatf("rd_valid[%0d]", i), 128'(rd_valid), 128'(i < nv));
        end
    endtask

    initial begin : driver
        logic [7:0] inv;
        int sc, base;
        bit hit;
        for (int b = 0; b < 256; b++) begin
            inv = 0;
            for (int c = 1; c < 256; c++) if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
            sbox[b] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int i = 0; i <= NR; i++) exp_store[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        chk("reset_outputs", {busy, done, error, en, word, rcon, kkey_o}, '0);
        check_store(0);

        // FIPS-197 vector with latency-2 F stage
        f_lat = 2;
        start_run(FIPS_KEY, sc);
        wait_done();
        rd_round = 4'd1; #1 chk("fips_round1", rd_key, FIPS_R1);
        rd_round = 4'd10; #1 chk("fips_round10", rd_key, FIPS_R10);
        check_store(NR + 1);

        for (int r = 0; r < 4; r++) begin
            f_lat = $urandom_range(0, 4);
            start_run(rnd128(), sc);
            wait_done();
            check_store(NR + 1);
        end

        // F stage never answers: timeout, earlier rounds of the store untouched
        f_never = 1;
        f_lat = 2;
        start_run(rnd128(), sc);
        for (int i = 0; i < 300 && !error; i++) begin
            @(posedge clk);
            #1;
        end
        chk("timeout_error", 128'(error), 128'(1));
        chk("timeout_cycle", 128'(cyc), 128'(sc + TO + 3));
        chk("timeout_busy", 128'(busy), 128'(0));
        chk("timeout_pending_reqs", 128'(req_q.size()), 128'(NR - 1));
        req_q.delete();
        done_q.delete();
        check_store(1);
        f_never = 0;
        start_run(FIPS_KEY, sc);
        wait_done();
        check_store(NR + 1);

        // Reset while waiting on round 5
        base = req_seen;
        start_run(rnd128(), sc);
        hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(posedge clk);
            #1;
            hit = req_seen >= base + 5;
        end
        if (!hit) fail("round5_timeout: got no round 5 request, expected one");
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        req_q.delete();
        done_q.delete();
        for (int i = 0; i <= NR; i++) exp_store[i] = '0;
        chk("midreset_outputs", {busy, done, error, en, word, rcon, kkey_o}, '0);
        check_store(0);
        repeat (80) @(posedge clk);
        #1;

        // Restart pulses and spurious ready outside WAIT must be ignored
        f_spur = 1;
        start_run(FIPS_KEY, sc);
        repeat (7) @(posedge clk);
        #1;
        key = rnd128();
        start = 1;
        repeat (20) @(posedge clk);
        #1;
        start = 0;
        wait_done();
        f_spur = 0;
        rd_round = 4'd1; #1 chk("spur_fips_round1", rd_key, FIPS_R1);
        rd_round = 4'd10; #1 chk("spur_fips_round10", rd_key, FIPS_R10);
        check_store(NR + 1);

        repeat (5) @(posedge clk);
        chk("leftover_requests", 128'(req_q.size()), 128'(0));
        chk("leftover_dones", 128'(done_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
